// File: rtl/stack_pkg.sv
// Shared types for the operand stack: per-cycle op encoding and the default width.
package stack_pkg;

    localparam int DATA_W_DEF = 8;

    // Encoded as {push, pop} so the strobes cast directly onto the op.
    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_PUSH    = 2'b10,
        OP_POP     = 2'b01,
        OP_REPLACE = 2'b11
    } stack_op_e;

endpackage

// File: rtl/operand_stack_mem.sv
// Entries below the top of stack: one write port, one async read port, no reset.
module operand_stack_mem #(
    parameter int DATA_W = 8,
    parameter int ENTRIES = 15,
    parameter int AW = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:ENTRIES-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/operand_stack.sv
// Operand stack with a registered TOS, occupancy counter and sticky error flags.
module operand_stack
    import stack_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic              err_clr,
    output logic [DATA_W-1:0] tos,
    output logic              tos_zero,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = $clog2(DEPTH);

    stack_op_e         op;
    logic [DATA_W-1:0] tos_n;
    logic [CNT_W-1:0]  count_n;
    logic [CNT_W-1:0]  wr_idx;
    logic [CNT_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              we;
    logic              ovf_set;
    logic              unf_set;

    assign op     = stack_op_e'({push, pop});
    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign tos_zero = (tos == '0) && !empty;

    // Indices wrap when count is small, but are only consumed under guards.
    assign wr_idx = count - CNT_W'(1);
    assign rd_idx = count - CNT_W'(2);

    operand_stack_mem #(
        .DATA_W  (DATA_W),
        .ENTRIES (DEPTH - 1),
        .AW      (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_idx[AW-1:0]),
        .wdata (tos),
        .raddr (rd_idx[AW-1:0]),
        .rdata (rd_data)
    );

    always_comb begin
        tos_n   = tos;
        count_n = count;
        we      = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case (op)
            OP_IDLE: begin
            end
            OP_PUSH: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    we      = !empty;
                    tos_n   = push_data;
                    count_n = count + CNT_W'(1);
                end
            end
            OP_POP: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else if (count == CNT_W'(1)) begin
                    tos_n   = '0;
                    count_n = '0;
                end else begin
                    tos_n   = rd_data;
                    count_n = count - CNT_W'(1);
                end
            end
            OP_REPLACE: begin
                tos_n = push_data;
                if (empty) begin
                    unf_set = 1'b1;
                    count_n = CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tos   <= '0;
            count <= '0;
        end else begin
            tos   <= tos_n;
            count <= count_n;
        end
    end

    // A fresh error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set || (overflow && !err_clr);
            underflow <= unf_set || (underflow && !err_clr);
        end
    end

endmodule
